ulpi_rx_capture: RTL

// - Parametrised ULPI receive-side capture engine for the USB3300 sniffer; successor to the single-depth receiver.
// - Sits between ULPI PHY pins and the UART/readout logic; runs entirely in the clk_ULPI (60 MHz) domain.
// - Buffers USB payload bytes in a data FIFO and emits one info record per bus turnaround: length, last RxCMD, flags.
// - Adds to the previous receiver: turnaround-cycle rejection, overflow truncation flags, info-drop counter.

---
 rtl/ulpi_rx_capture.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ulpi_rx_capture.sv
// ulpi_rx_capture: ULPI receive-side capture engine (USB3300 sniffer).
// Runs entirely in the clk_ULPI domain. All state updates happen on the falling edge.
// USB payload bytes go into a data FIFO. One info record is emitted for each bus
// turnaround: {trunc, has_data, rx_cmd[5:0], len}.
// Optional macro ULPI_RX_TIMESTAMP_EN adds a free-running TS_W counter. It is latched
// at TURN entry and prepended to info_out as the MSBs.
// Ports:
//   clk_ULPI, rst (async, active-high)
//   capture_en (sampled in IDLE), busy (state != IDLE)
//   DIR, NXT, DATA_I                        ULPI PHY->link
//   DATA_O, STP                             tied low (receive-only)
//   rx_cmd                                  last RxCMD byte
//   data_re/data_out/data_full/data_empty   payload FIFO read side
//   info_re/info_out/info_full/info_empty   record FIFO read side
//   drop_cnt                                records lost to a full info FIFO (saturating)
module ulpi_rx_capture #(
  parameter int DATA_AW = 9,
  parameter int INFO_AW = 5,
  parameter int LEN_W   = 11,
  parameter int DROP_W  = 8,
  parameter int TS_W    = 16,
`ifdef ULPI_RX_TIMESTAMP_EN
  localparam int INFO_W = TS_W + LEN_W + 8
`else
  // TS_W stays in the list so that parameter overrides compile in both builds.
  localparam int INFO_W = LEN_W + 8 + (TS_W * 0)
`endif
) (
  input  logic              clk_ULPI,
  input  logic              rst,
  input  logic              capture_en,
  output logic              busy,
  input  logic              DIR,
  input  logic              NXT,
  input  logic [7:0]        DATA_I,
  output logic [7:0]        DATA_O,
  output logic              STP,
  output logic [7:0]        rx_cmd,
  input  logic              data_re,
  output logic [7:0]        data_out,
  output logic              data_full,
  output logic              data_empty,
  input  logic              info_re,
  output logic [INFO_W-1:0] info_out,
  output logic              info_full,
  output logic              info_empty,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int DDEPTH = 1 << DATA_AW;
  localparam int IDEPTH = 1 << INFO_AW;

  typedef enum logic [1:0] {IDLE, TURN, RECV, CLOSE} state_t;

  state_t            state;
  logic              dir_q;
  logic [LEN_W-1:0]  len;
  logic              trunc;
  logic              has_data;
  logic              wr_pend;
  logic [7:0]        wr_byte;
  logic              start;
  logic [INFO_W-1:0] rec;

  assign DATA_O = '0;
  assign STP    = 1'b0;
  assign start  = (state == IDLE) && capture_en && DIR && !dir_q;

  // ---------------- control FSM ----------------
  always_ff @(negedge clk_ULPI or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      dir_q    <= 1'b0;
      len      <= '0;
      trunc    <= 1'b0;
      has_data <= 1'b0;
      wr_pend  <= 1'b0;
      wr_byte  <= '0;
      rx_cmd   <= '0;
      drop_cnt <= '0;
    end else begin
      dir_q   <= DIR;
      wr_pend <= 1'b0;
      // A staged byte that meets a full FIFO poisons the rest of the packet.
      if (wr_pend && data_full) trunc <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= TURN;
            busy     <= 1'b1;
            len      <= '0;
            trunc    <= 1'b0;
            has_data <= 1'b0;
          end
        end
        TURN: begin
          if (DIR) begin
            state <= RECV;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RECV: begin
          if (!DIR) begin
            state <= CLOSE;
          end else if (NXT) begin
            wr_pend  <= 1'b1;
            wr_byte  <= DATA_I;
            has_data <= 1'b1;
            if (len != '1) len <= len + LEN_W'(1);
          end else begin
            rx_cmd <= DATA_I;
          end
        end
        CLOSE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (info_full && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ULPI_RX_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_lat;

  always_ff @(negedge clk_ULPI or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (start) ts_lat <= ts_cnt;
    end
  end

  assign rec = {ts_lat, trunc, has_data, rx_cmd[5:0], len};
`else
  assign rec = {trunc, has_data, rx_cmd[5:0], len};
`endif

  // ---------------- data FIFO ----------------
  logic [7:0]         dmem [DDEPTH];
  logic [DATA_AW-1:0] dwp, drp;
  logic [DATA_AW:0]   dcnt;
  logic               dwe, dre;

  assign dwe        = wr_pend && !trunc && !data_full;
  assign dre        = data_re && !data_empty;
  // The count never exceeds DDEPTH, so its MSB alone marks full.
  assign data_full  = dcnt[DATA_AW];
  assign data_empty = (dcnt == '0);

  always_ff @(negedge clk_ULPI) begin
    if (dwe) dmem[dwp] <= wr_byte;
  end

  always_ff @(negedge clk_ULPI or posedge rst) begin
    if (rst) begin
      dwp      <= '0;
      drp      <= '0;
      dcnt     <= '0;
      data_out <= '0;
    end else begin
      if (dwe) dwp <= dwp + DATA_AW'(1);
      if (dre) begin
        drp      <= drp + DATA_AW'(1);
        data_out <= dmem[drp];
      end
      case ({dwe, dre})
        2'b10:   dcnt <= dcnt + (DATA_AW + 1)'(1);
        2'b01:   dcnt <= dcnt - (DATA_AW + 1)'(1);
        default: dcnt <= dcnt;
      endcase
    end
  end

  // ---------------- info FIFO ----------------
  logic [INFO_W-1:0]  imem [IDEPTH];
  logic [INFO_AW-1:0] iwp, irp;
  logic [INFO_AW:0]   icnt;
  logic               iwe, ire;

  assign iwe        = (state == CLOSE) && !info_full;
  assign ire        = info_re && !info_empty;
  assign info_full  = icnt[INFO_AW];
  assign info_empty = (icnt == '0);

  always_ff @(negedge clk_ULPI) begin
    if (iwe) imem[iwp] <= rec;
  end

  always_ff @(negedge clk_ULPI or posedge rst) begin
    if (rst) begin
      iwp      <= '0;
      irp      <= '0;
      icnt     <= '0;
      info_out <= '0;
    end else begin
      if (iwe) iwp <= iwp + INFO_AW'(1);
      if (ire) begin
        irp      <= irp + INFO_AW'(1);
        info_out <= imem[irp];
      end
      case ({iwe, ire})
        2'b10:   icnt <= icnt + (INFO_AW + 1)'(1);
        2'b01:   icnt <= icnt - (INFO_AW + 1)'(1);
        default: icnt <= icnt;
      endcase
    end
  end

endmodule
